// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter and its fill sequencer.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WRITE  = 2'd1,
      FILL_I = 2'd2,
      FILL_D = 2'd3
   } arb_state_e;

   localparam int BLOCK_WORDS_DEF = 8;
   localparam int MEM_LAT_DEF     = 4;

   // Width of a word index inside a block; kept at least one bit wide.
   function automatic int word_w(input int words);
      return (words > 1) ? $clog2(words) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side requests, memory bus and fill stream of the shared-memory arbiter.
interface mem_arbiter_if #(
   parameter int ADDR_W      = 16,
   parameter int DATA_W      = 16,
   parameter int BLOCK_WORDS = mem_arb_pkg::BLOCK_WORDS_DEF,
   localparam int WORD_W     = mem_arb_pkg::word_w(BLOCK_WORDS)
) ();

   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              d_req;
   logic [ADDR_W-1:0] d_addr;
   logic              d_wr;
   logic [DATA_W-1:0] d_wdata;

   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_valid;

   logic [DATA_W-1:0] fill_data;
   logic [WORD_W-1:0] fill_word;
   logic              i_fill_we;
   logic              d_fill_we;
   logic              i_done;
   logic              d_done;
   logic              d_wr_done;
   logic              busy;

   modport master (
      input  i_req, i_addr, d_req, d_addr, d_wr, d_wdata, mem_rdata, mem_valid,
      output mem_en, mem_wr, mem_addr, mem_wdata,
      output fill_data, fill_word, i_fill_we, d_fill_we,
      output i_done, d_done, d_wr_done, busy
   );

   modport slave (
      output i_req, i_addr, d_req, d_addr, d_wr, d_wdata, mem_rdata, mem_valid,
      input  mem_en, mem_wr, mem_addr, mem_wdata,
      input  fill_data, fill_word, i_fill_we, d_fill_we,
      input  i_done, d_done, d_wr_done, busy
   );

endinterface

// File: rtl/mem_fill_seq.sv
// Block-fill sequencer: issue/receive word counters and in-block read addresses.
module mem_fill_seq
   import mem_arb_pkg::*;
#(
   parameter int  ADDR_W      = 16,
   parameter int  BLOCK_WORDS = BLOCK_WORDS_DEF,
   localparam int WORD_W      = word_w(BLOCK_WORDS),
   localparam int BLK_W       = ADDR_W - WORD_W - 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              issue,
   input  logic              recv,
   input  logic [BLK_W-1:0]  blk,
   output logic [ADDR_W-1:0] issue_addr,
   output logic [WORD_W-1:0] recv_idx,
   output logic              last_issue,
   output logic              last_recv
);

   localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BLOCK_WORDS - 1);

   logic [WORD_W-1:0] issue_cnt;
   logic [WORD_W-1:0] recv_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_cnt <= '0;
         recv_cnt  <= '0;
      end else if (start) begin
         issue_cnt <= '0;
         recv_cnt  <= '0;
      end else begin
         if (issue) issue_cnt <= issue_cnt + 1'b1;
         if (recv)  recv_cnt  <= recv_cnt + 1'b1;
      end
   end

   // Word index replaces the in-block bits, so reads never carry out of the block.
   assign issue_addr = {blk, issue_cnt, 1'b0};
   assign recv_idx   = recv_cnt;
   assign last_issue = issue && (issue_cnt == LAST_WORD);
   assign last_recv  = recv && (recv_cnt == LAST_WORD);

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter for D-write, D-fill and I-fill onto the shared main memory.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int  ADDR_W      = 16,
   parameter int  DATA_W      = 16,
   parameter int  BLOCK_WORDS = BLOCK_WORDS_DEF,
   parameter int  MEM_LAT     = MEM_LAT_DEF,
   localparam int WORD_W      = word_w(BLOCK_WORDS),
   localparam int BLK_W       = ADDR_W - WORD_W - 1
) (
   input  logic          clk,
   input  logic          rst_n,
   mem_arbiter_if.master bus
);

   if (MEM_LAT < 1) begin : g_lat_check
      $error("mem_arbiter: MEM_LAT must be at least 1");
   end
   if ((BLOCK_WORDS < 2) || ((1 << WORD_W) != BLOCK_WORDS)) begin : g_bw_check
      $error("mem_arbiter: BLOCK_WORDS must be a power of two >= 2");
   end

   arb_state_e        state_q;
   arb_state_e        state_d;
   logic              issuing_q;
   logic              start;
   logic              fill_state;
   logic              recv;
   logic              last_issue;
   logic              last_recv;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [ADDR_W-1:0] issue_addr;
   logic [WORD_W-1:0] recv_idx;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.d_wr)       state_d = WRITE;
            else if (bus.d_req) state_d = FILL_D;
            else if (bus.i_req) state_d = FILL_I;
         end
         WRITE:          state_d = IDLE;
         FILL_I, FILL_D: if (last_recv) state_d = IDLE;
         default:        state_d = IDLE;
      endcase
   end

   assign start = (state_q == IDLE) && ((state_d == FILL_I) || (state_d == FILL_D));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         issuing_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (start)           issuing_q <= 1'b1;
         else if (last_issue) issuing_q <= 1'b0;
      end
   end

   // Winner's address and data are captured every IDLE cycle; outputs gate them.
   always_ff @(posedge clk) begin
      if (state_q == IDLE) begin
         addr_q  <= (bus.d_wr || bus.d_req) ? bus.d_addr : bus.i_addr;
         wdata_q <= bus.d_wdata;
      end
   end

   assign fill_state = (state_q == FILL_I) || (state_q == FILL_D);
   assign recv       = fill_state && bus.mem_valid;

   mem_fill_seq #(
      .ADDR_W      (ADDR_W),
      .BLOCK_WORDS (BLOCK_WORDS)
   ) u_seq (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .issue      (issuing_q),
      .recv       (recv),
      .blk        (addr_q[ADDR_W-1 -: BLK_W]),
      .issue_addr (issue_addr),
      .recv_idx   (recv_idx),
      .last_issue (last_issue),
      .last_recv  (last_recv)
   );

   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (state_q == WRITE) begin
         bus.mem_en    = 1'b1;
         bus.mem_wr    = 1'b1;
         bus.mem_addr  = addr_q;
         bus.mem_wdata = wdata_q;
      end else if (issuing_q) begin
         bus.mem_en   = 1'b1;
         bus.mem_addr = issue_addr;
      end
   end

   assign bus.fill_data = recv ? bus.mem_rdata : '0;
   assign bus.fill_word = recv_idx;
   assign bus.i_fill_we = (state_q == FILL_I) && bus.mem_valid;
   assign bus.d_fill_we = (state_q == FILL_D) && bus.mem_valid;
   assign bus.i_done    = (state_q == FILL_I) && last_recv;
   assign bus.d_done    = (state_q == FILL_D) && last_recv;
   assign bus.d_wr_done = (state_q == WRITE);
   assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a pipelined memory model of fixed latency.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int ADDR_W = 16;
   localparam int DATA_W = 16;
   localparam int BW     = 8;
   localparam int LAT    = 4;

   typedef struct {
      int          cyc;
      logic [15:0] addr;
   } iss_t;

   typedef struct {
      int          cyc;
      logic        side_d;
      logic [2:0]  word;
      logic [15:0] data;
   } fil_t;

   typedef struct {
      int          cyc;
      logic        en, wr;
      logic [15:0] addr, wdata;
      logic        iwe, dwe;
      logic [2:0]  word;
      logic [15:0] data;
      logic        idone, ddone, wdone, busy;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n;
   logic spur;

   int n_checks = 0;
   int n_fail   = 0;

   iss_t iss_q[$];
   fil_t fil_q[$];
   obs_t obs_q[$];

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BLOCK_WORDS(BW)) bus ();

   mem_arbiter #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .BLOCK_WORDS (BW),
      .MEM_LAT     (LAT)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return a ^ 16'hC3A5;
   endfunction

   // Memory model: read data returns LAT cycles after the issue cycle.
   logic [LAT-1:0] vld_pipe;
   logic [15:0]    dat_pipe [LAT];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_pipe <= '0;
         for (int i = 0; i < LAT; i++) dat_pipe[i] <= '0;
      end else begin
         vld_pipe    <= {vld_pipe[LAT-2:0], bus.mem_en & ~bus.mem_wr};
         dat_pipe[0] <= mem_word(bus.mem_addr);
         for (int i = 1; i < LAT; i++) dat_pipe[i] <= dat_pipe[i-1];
      end
   end

   assign bus.mem_valid = vld_pipe[LAT-1] | spur;
   assign bus.mem_rdata = spur ? 16'hDEAD : dat_pipe[LAT-1];

   a_i_hold: assert property (@(posedge clk) disable iff (!rst_n) $fell(bus.i_req) |-> $past(bus.i_done));
   a_d_hold: assert property (@(posedge clk) disable iff (!rst_n) $fell(bus.d_req) |-> $past(bus.d_done));
   a_w_hold: assert property (@(posedge clk) disable iff (!rst_n) $fell(bus.d_wr) |-> $past(bus.d_wr_done));

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   function automatic bit inr(input int c, input int lo, input int hi);
      return (c >= lo) && (c <= hi);
   endfunction

   function automatic logic [63:0] outs_vec();
      return 64'({bus.mem_en, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.fill_data, bus.fill_word,
                  bus.i_fill_we, bus.d_fill_we, bus.i_done, bus.d_done, bus.d_wr_done, bus.busy});
   endfunction

   task automatic push_fill(input int c0, input logic [15:0] addr, input logic side_d);
      logic [15:0] base;
      base = addr & 16'hFFF0;
      for (int k = 0; k < BW; k++) begin
         iss_q.push_back('{cyc: c0 + 1 + k, addr: base + 16'(2 * k)});
         fil_q.push_back('{cyc: c0 + 1 + LAT + k, side_d: side_d, word: 3'(k), data: mem_word(base + 16'(2 * k))});
      end
   endtask

   // Records n cycles (cycle 0 = current one) and releases requests after their done pulse.
   task automatic sample(input int n);
      obs_q.delete();
      for (int c = 0; c < n; c++) begin
         obs_t o;
         @(negedge clk);
         o.cyc = c;         o.en = bus.mem_en;        o.wr = bus.mem_wr;
         o.addr = bus.mem_addr; o.wdata = bus.mem_wdata;
         o.iwe = bus.i_fill_we; o.dwe = bus.d_fill_we; o.word = bus.fill_word; o.data = bus.fill_data;
         o.idone = bus.i_done;  o.ddone = bus.d_done;  o.wdone = bus.d_wr_done; o.busy = bus.busy;
         obs_q.push_back(o);
         @(posedge clk);
         #1;
         if (o.idone) bus.i_req = 1'b0;
         if (o.ddone) bus.d_req = 1'b0;
         if (o.wdone) bus.d_wr  = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      spur = 1'b0;
      bus.i_req = 1'b0; bus.i_addr = '0; bus.d_req = 1'b0; bus.d_addr = '0;
      bus.d_wr = 1'b0;  bus.d_wdata = '0;
      @(negedge clk);
      n_checks++;
      if (outs_vec() !== 64'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs_vec()); end
      bus.i_req = 1'b1;
      @(negedge clk);
      n_checks++;
      if ({bus.busy, bus.mem_en} !== 2'b00) begin n_fail++; $display("FAIL reset_hold_req: busy/mem_en %b expected 00", {bus.busy, bus.mem_en}); end
      bus.i_req = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      n_checks++;
      if (outs_vec() !== 64'd0) begin n_fail++; $display("FAIL post_reset_idle: got %h expected 0", outs_vec()); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_spurious_valid();
      spur = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_checks++;
         if ({bus.i_fill_we, bus.d_fill_we, bus.i_done, bus.d_done, bus.busy, bus.fill_word} !== 8'd0) begin
            n_fail++;
            $display("FAIL spurious_valid cyc %0d: we/done/busy/word %b expected 0", c,
                     {bus.i_fill_we, bus.d_fill_we, bus.i_done, bus.d_done, bus.busy, bus.fill_word});
         end
         @(posedge clk);
         #1;
         if (c == 2) spur = 1'b0;
      end
   endtask

   task automatic test_fill();
      bit          sides [2];
      logic [15:0] addrs [2];
      sides = '{1'b0, 1'b1};
      addrs = '{16'h0034, 16'hFFF2};
      for (int t = 0; t < 2; t++) begin
         push_fill(0, addrs[t], sides[t]);
         if (sides[t]) begin bus.d_req = 1'b1; bus.d_addr = addrs[t]; end
         else begin bus.i_req = 1'b1; bus.i_addr = addrs[t]; end
         sample(15);
         foreach (obs_q[j]) begin
            obs_t o;
            iss_t ie;
            fil_t fe;
            bit   ef;
            o  = obs_q[j];
            ef = inr(o.cyc, 5, 12);
            n_checks++;
            if ({o.en, o.wr, o.busy} !== {inr(o.cyc, 1, 8), 1'b0, inr(o.cyc, 1, 12)}) begin
               n_fail++; $display("FAIL fill%0d en/wr/busy cyc %0d: got %b", t, o.cyc, {o.en, o.wr, o.busy});
            end
            n_checks++;
            if ({o.iwe, o.dwe, o.idone, o.ddone, o.wdone} !==
                {ef & ~sides[t], ef & sides[t], (o.cyc == 12) & ~sides[t], (o.cyc == 12) & sides[t], 1'b0}) begin
               n_fail++; $display("FAIL fill%0d we/done cyc %0d: got %b", t, o.cyc, {o.iwe, o.dwe, o.idone, o.ddone, o.wdone});
            end
            if (o.en === 1'b1 && o.wr === 1'b0) begin
               n_checks++;
               if (iss_q.size() == 0) begin n_fail++; $display("FAIL fill%0d extra read cyc %0d addr %h", t, o.cyc, o.addr); end
               else begin
                  ie = iss_q.pop_front();
                  if (o.cyc != ie.cyc || o.addr !== ie.addr) begin
                     n_fail++; $display("FAIL fill%0d read: got cyc %0d addr %h expected cyc %0d addr %h", t, o.cyc, o.addr, ie.cyc, ie.addr);
                  end
               end
            end
            if (o.iwe === 1'b1 || o.dwe === 1'b1) begin
               n_checks++;
               if (fil_q.size() == 0) begin n_fail++; $display("FAIL fill%0d extra return cyc %0d", t, o.cyc); end
               else begin
                  fe = fil_q.pop_front();
                  if (o.cyc != fe.cyc || {o.dwe, o.word, o.data} !== {fe.side_d, fe.word, fe.data}) begin
                     n_fail++; $display("FAIL fill%0d return: got cyc %0d d %b word %0d data %h expected cyc %0d d %b word %0d data %h",
                                        t, o.cyc, o.dwe, o.word, o.data, fe.cyc, fe.side_d, fe.word, fe.data);
                  end
               end
            end
         end
         n_checks++;
         if (iss_q.size() != 0 || fil_q.size() != 0) begin
            n_fail++; $display("FAIL fill%0d missing: %0d reads, %0d returns outstanding expected 0", t, iss_q.size(), fil_q.size());
            iss_q.delete(); fil_q.delete();
         end
      end
   endtask

   task automatic test_priority();
      push_fill(0, 16'h1002, 1'b1);
      push_fill(13, 16'h0456, 1'b0);
      bus.d_req = 1'b1; bus.d_addr = 16'h1002;
      bus.i_req = 1'b1; bus.i_addr = 16'h0456;
      sample(28);
      foreach (obs_q[j]) begin
         obs_t o;
         iss_t ie;
         fil_t fe;
         o = obs_q[j];
         n_checks++;
         if ({o.en, o.wr, o.busy} !== {inr(o.cyc, 1, 8) | inr(o.cyc, 14, 21), 1'b0, inr(o.cyc, 1, 12) | inr(o.cyc, 14, 25)}) begin
            n_fail++; $display("FAIL prio en/wr/busy cyc %0d: got %b", o.cyc, {o.en, o.wr, o.busy});
         end
         n_checks++;
         if ({o.iwe, o.dwe, o.idone, o.ddone} !== {inr(o.cyc, 18, 25), inr(o.cyc, 5, 12), o.cyc == 25, o.cyc == 12}) begin
            n_fail++; $display("FAIL prio we/done cyc %0d: got %b", o.cyc, {o.iwe, o.dwe, o.idone, o.ddone});
         end
         if (o.en === 1'b1 && o.wr === 1'b0) begin
            n_checks++;
            if (iss_q.size() == 0) begin n_fail++; $display("FAIL prio extra read cyc %0d addr %h", o.cyc, o.addr); end
            else begin
               ie = iss_q.pop_front();
               if (o.cyc != ie.cyc || o.addr !== ie.addr) begin
                  n_fail++; $display("FAIL prio read: got cyc %0d addr %h expected cyc %0d addr %h", o.cyc, o.addr, ie.cyc, ie.addr);
               end
            end
         end
         if (o.iwe === 1'b1 || o.dwe === 1'b1) begin
            n_checks++;
            if (fil_q.size() == 0) begin n_fail++; $display("FAIL prio extra return cyc %0d", o.cyc); end
            else begin
               fe = fil_q.pop_front();
               if (o.cyc != fe.cyc || {o.dwe, o.word, o.data} !== {fe.side_d, fe.word, fe.data}) begin
                  n_fail++; $display("FAIL prio return: got cyc %0d d %b word %0d data %h expected cyc %0d d %b word %0d data %h",
                                     o.cyc, o.dwe, o.word, o.data, fe.cyc, fe.side_d, fe.word, fe.data);
               end
            end
         end
      end
      n_checks++;
      if (iss_q.size() != 0 || fil_q.size() != 0) begin
         n_fail++; $display("FAIL prio missing: %0d reads, %0d returns outstanding expected 0", iss_q.size(), fil_q.size());
         iss_q.delete(); fil_q.delete();
      end
   endtask

   task automatic test_write_then_fill();
      push_fill(2, 16'h0200, 1'b1);
      bus.d_wr = 1'b1; bus.d_req = 1'b1; bus.d_addr = 16'h0200; bus.d_wdata = 16'hBEEF;
      sample(17);
      foreach (obs_q[j]) begin
         obs_t o;
         iss_t ie;
         fil_t fe;
         o = obs_q[j];
         n_checks++;
         if ({o.en, o.wr, o.wdone, o.busy} !== {(o.cyc == 1) | inr(o.cyc, 3, 10), o.cyc == 1, o.cyc == 1, (o.cyc == 1) | inr(o.cyc, 3, 14)}) begin
            n_fail++; $display("FAIL wr en/wr/wdone/busy cyc %0d: got %b", o.cyc, {o.en, o.wr, o.wdone, o.busy});
         end
         n_checks++;
         if ({o.iwe, o.dwe, o.idone, o.ddone} !== {1'b0, inr(o.cyc, 7, 14), 1'b0, o.cyc == 14}) begin
            n_fail++; $display("FAIL wr we/done cyc %0d: got %b", o.cyc, {o.iwe, o.dwe, o.idone, o.ddone});
         end
         if (o.cyc == 1) begin
            n_checks++;
            if ({o.addr, o.wdata} !== {16'h0200, 16'hBEEF}) begin
               n_fail++; $display("FAIL wr beat: got addr %h data %h expected 0200 BEEF", o.addr, o.wdata);
            end
         end
         if (o.en === 1'b1 && o.wr === 1'b0) begin
            n_checks++;
            if (iss_q.size() == 0) begin n_fail++; $display("FAIL wr extra read cyc %0d addr %h", o.cyc, o.addr); end
            else begin
               ie = iss_q.pop_front();
               if (o.cyc != ie.cyc || o.addr !== ie.addr) begin
                  n_fail++; $display("FAIL wr read: got cyc %0d addr %h expected cyc %0d addr %h", o.cyc, o.addr, ie.cyc, ie.addr);
               end
            end
         end
         if (o.iwe === 1'b1 || o.dwe === 1'b1) begin
            n_checks++;
            if (fil_q.size() == 0) begin n_fail++; $display("FAIL wr extra return cyc %0d", o.cyc); end
            else begin
               fe = fil_q.pop_front();
               if (o.cyc != fe.cyc || {o.dwe, o.word, o.data} !== {fe.side_d, fe.word, fe.data}) begin
                  n_fail++; $display("FAIL wr return: got cyc %0d d %b word %0d data %h expected cyc %0d d %b word %0d data %h",
                                     o.cyc, o.dwe, o.word, o.data, fe.cyc, fe.side_d, fe.word, fe.data);
               end
            end
         end
      end
      n_checks++;
      if (iss_q.size() != 0 || fil_q.size() != 0) begin
         n_fail++; $display("FAIL wr missing: %0d reads, %0d returns outstanding expected 0", iss_q.size(), fil_q.size());
         iss_q.delete(); fil_q.delete();
      end
   endtask

   task automatic test_reset_mid_fill();
      bus.i_req = 1'b1; bus.i_addr = 16'h0100;
      sample(6);
      n_checks++;
      if ({obs_q[5].en, obs_q[5].iwe, obs_q[5].word, obs_q[5].data} !== {1'b1, 1'b1, 3'd0, mem_word(16'h0100)}) begin
         n_fail++; $display("FAIL rst_pre cyc 5: en/we/word/data %b/%b/%0d/%h expected 1/1/0/%h",
                            obs_q[5].en, obs_q[5].iwe, obs_q[5].word, obs_q[5].data, mem_word(16'h0100));
      end
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (outs_vec() !== 64'd0) begin n_fail++; $display("FAIL rst_async_outputs: got %h expected 0", outs_vec()); end
      bus.i_req = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      sample(20);
      foreach (obs_q[j]) begin
         n_checks++;
         if ({obs_q[j].en, obs_q[j].iwe, obs_q[j].dwe, obs_q[j].idone, obs_q[j].ddone, obs_q[j].wdone, obs_q[j].busy} !== 7'd0) begin
            n_fail++; $display("FAIL rst_after cyc %0d: en/we/done/busy %b expected 0", obs_q[j].cyc,
                               {obs_q[j].en, obs_q[j].iwe, obs_q[j].dwe, obs_q[j].idone, obs_q[j].ddone, obs_q[j].wdone, obs_q[j].busy});
         end
      end
   endtask

   initial begin
      test_reset();
      test_spurious_valid();
      test_fill();
      test_priority();
      test_write_then_fill();
      test_reset_mid_fill();
      test_fill();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
